// File: rtl/coreabc_ram_loader_pkg.sv
// coreabc_pkg: shared RAM geometry and loader FSM states
package coreabc_pkg;
   localparam int RAM_AW = 8;
   localparam int RAM_DW = 16;
   typedef enum logic [2:0] {IDLE, LOAD, VERIFY, DRAIN, CHECK} state_t;
endpackage

// File: rtl/coreabc_ram_loader_if.sv
// coreabc_ram_loader_if: host stream, control/status and RAM port bundle of the loader
interface coreabc_ram_loader_if import coreabc_pkg::*; #(parameter int AW = RAM_AW, parameter int DW = RAM_DW);
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          ram_wen;
   logic [AW-1:0] ram_waddr;
   logic [DW-1:0] ram_wd;
   logic          ram_ren;
   logic [AW-1:0] ram_raddr;
   logic [DW-1:0] ram_rd;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW:0]   count;
   modport master (
      input  start, base_addr, length, s_valid, s_data, ram_rd,
      output s_ready, ram_wen, ram_waddr, ram_wd, ram_ren, ram_raddr, busy, done, error, count
   );
   modport slave (
      output start, base_addr, length, s_valid, s_data, ram_rd,
      input  s_ready, ram_wen, ram_waddr, ram_wd, ram_ren, ram_raddr, busy, done, error, count
   );
endinterface

// File: rtl/coreabc_ram_loader_cksum.sv
// coreabc_cksum16: DW-bit wrapping accumulator with synchronous clear and enable
module coreabc_cksum16 #(parameter int DW = 16) (
   input  logic          RWCLK,
   input  logic          RESET,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] sum
);
   always_ff @(posedge RWCLK)
      sum <= (RESET || clr) ? '0 : en ? sum + d : sum;
endmodule

// File: rtl/coreabc_ram_loader.sv
// coreabc_ram_loader: streams words into RAM from a base address, reads the region back
// and flags a checksum mismatch between written and read-back words.
module coreabc_ram_loader import coreabc_pkg::*; #(
   parameter int AW = RAM_AW,
   parameter int DW = RAM_DW
) (
   input logic RWCLK,
   input logic RESET,
   coreabc_ram_loader_if.master bus
);
   localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
   state_t        state;
   logic [AW-1:0] base;
   logic [AW:0]   len, cnt, rd_idx, len_in;
   logic          rd_pend, go, hs, done_q, error_q;
   logic [DW-1:0] sum_wr, sum_rd;
   assign len_in = bus.length > FULL ? FULL : bus.length;
   assign go = state == IDLE && bus.start;
   assign hs = state == LOAD && bus.s_valid;
   assign bus.s_ready   = state == LOAD;
   assign bus.ram_wen   = hs;
   assign bus.ram_waddr = base + cnt[AW-1:0];
   assign bus.ram_wd    = state == LOAD ? bus.s_data : '0;
   assign bus.ram_ren   = state == VERIFY;
   assign bus.ram_raddr = base + rd_idx[AW-1:0];
   assign bus.busy      = state != IDLE;
   assign bus.done      = done_q;
   assign bus.error     = error_q;
   assign bus.count     = cnt;
   coreabc_cksum16 #(.DW(DW)) u_sum_wr (
      .RWCLK(RWCLK), .RESET(RESET), .clr(go), .en(hs), .d(bus.s_data), .sum(sum_wr)
   );
   // read data arrives one cycle after each VERIFY read, so rd_pend gates the read-side sum
   coreabc_cksum16 #(.DW(DW)) u_sum_rd (
      .RWCLK(RWCLK), .RESET(RESET), .clr(go), .en(rd_pend), .d(bus.ram_rd), .sum(sum_rd)
   );
   // a zero-length load pulses DONE as it enters CHECK; real loads pulse it after CHECK
   always_ff @(posedge RWCLK) begin
      if (RESET) begin
         state   <= IDLE;
         base    <= '0;
         len     <= '0;
         cnt     <= '0;
         rd_idx  <= '0;
         rd_pend <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         rd_pend <= state == VERIFY;
         done_q  <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               base    <= bus.base_addr;
               len     <= len_in;
               cnt     <= '0;
               rd_idx  <= '0;
               error_q <= 1'b0;
               done_q  <= len_in == '0;
               state   <= len_in == '0 ? CHECK : LOAD;
            end
            LOAD: if (bus.s_valid) begin
               cnt <= cnt + 1'b1;
               if (cnt == len - 1'b1) state <= VERIFY;
            end
            VERIFY: begin
               rd_idx <= rd_idx + 1'b1;
               if (rd_idx == len - 1'b1) state <= DRAIN;
            end
            DRAIN: state <= CHECK;
            CHECK: begin
               error_q <= sum_wr != sum_rd;
               done_q  <= len != '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_coreabc_ram_loader.sv
// tb_coreabc_ram_loader: randomized loads against a queue-based reference of writes, reads and completions
module tb_coreabc_ram_loader;
   typedef struct {int cnt; bit err; int lat;} done_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int start_cyc = 0;
   logic [15:0] ram [256];
   logic [15:0] mem_exp [256];
   bit known [256];
   bit corrupt_req = 1'b0;
   logic [7:0] corrupt_addr = '0;
   logic [23:0] exp_wr [$];
   logic [7:0] exp_rd [$];
   done_t exp_done [$];

   coreabc_ram_loader_if bus ();
   coreabc_ram_loader dut (.RWCLK(clk), .RESET(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 256x16 RAM model with a bench-side write mux used to corrupt one word after LOAD
   always @(posedge clk) begin
      if (bus.ram_wen) ram[bus.ram_waddr] <= bus.ram_wd;
      else if (corrupt_req && bus.ram_ren && bus.ram_raddr == corrupt_addr)
         ram[corrupt_addr + 8'd1] <= ~ram[corrupt_addr + 8'd1];
      if (bus.ram_ren) bus.ram_rd <= ram[bus.ram_raddr];
   end

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endfunction

   initial begin
      logic [23:0] w;
      logic [7:0] r;
      done_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.ram_wen && bus.ram_ren) chk("wen_ren_overlap", 1, 0);
            if (bus.ram_wen) begin
               if (exp_wr.size() == 0) chk("extra_write", bus.ram_waddr, 9'h100);
               else begin
                  w = exp_wr.pop_front();
                  chk("wr_addr", bus.ram_waddr, w[23:16]);
                  chk("wr_data", bus.ram_wd, w[15:0]);
               end
            end
            if (bus.ram_ren) begin
               if (exp_rd.size() == 0) chk("extra_read", bus.ram_raddr, 9'h100);
               else begin
                  r = exp_rd.pop_front();
                  chk("rd_addr", bus.ram_raddr, r);
               end
            end
            if (bus.done) begin
               if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
               else begin
                  e = exp_done.pop_front();
                  chk("done_count", bus.count, e.cnt);
                  chk("done_error", bus.error, e.err);
                  chk("writes_left", exp_wr.size(), 0);
                  chk("reads_left", exp_rd.size(), 0);
                  if (e.lat >= 0) chk("done_latency", cyc - start_cyc, e.lat);
               end
            end
         end
      end
   end

   task automatic chk_reset_outputs(string tag);
      chk({tag, "_s_ready"}, bus.s_ready, 0);
      chk({tag, "_wen"}, bus.ram_wen, 0);
      chk({tag, "_ren"}, bus.ram_ren, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_error"}, bus.error, 0);
      chk({tag, "_count"}, bus.count, 0);
      chk({tag, "_waddr"}, bus.ram_waddr, 0);
      chk({tag, "_raddr"}, bus.ram_raddr, 0);
      chk({tag, "_wd"}, bus.ram_wd, 0);
   endtask

   task automatic chk_ram(string name);
      int bad = 0;
      for (int k = 0; k < 256; k++) if (known[k] && ram[k] !== mem_exp[k]) bad++;
      chk(name, bad, 0);
   endtask

   task automatic run_load(input int base, input int len, input bit gaps, input bit seq,
                           input bit corrupt, input int abort_at);
      int n, target, i, guard;
      bit gap, hs;
      logic [15:0] d [$];
      done_t e;
      n = len > 256 ? 256 : len;
      target = abort_at < 0 ? n : abort_at;
      for (int k = 0; k < n; k++) d.push_back(seq ? 16'(k + 1) : 16'($urandom));
      for (int k = 0; k < target; k++) exp_wr.push_back({8'(base + k), d[k]});
      if (abort_at < 0) begin
         for (int k = 0; k < n; k++) exp_rd.push_back(8'(base + k));
         e.cnt = n;
         e.err = corrupt && n >= 2;
         e.lat = n == 0 ? 1 : gaps ? -1 : 2 * n + 3;
         exp_done.push_back(e);
      end
      corrupt_addr = 8'(base);
      corrupt_req = corrupt;
      bus.start = 1'b1;
      bus.base_addr = 8'(base);
      bus.length = 9'(len);
      start_cyc = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("error_cleared_on_start", bus.error, 0);
      chk("busy_after_start", bus.busy, 1);
      i = 0;
      guard = 0;
      while (i < target && guard < 4000) begin
         gap = gaps && $urandom_range(0, 2) == 0;
         bus.s_valid = !gap;
         bus.s_data = d[i];
         hs = !gap && bus.s_ready;
         @(posedge clk); #1;
         guard++;
         if (hs) i++;
      end
      bus.s_valid = 1'b0;
      chk("words_accepted", i, target);
      for (int k = 0; k < target; k++) begin
         mem_exp[8'(base + k)] = d[k];
         known[8'(base + k)] = 1'b1;
      end
      if (abort_at >= 0) begin
         rst = 1'b1;
         @(posedge clk); #1;
         chk("abort_writes_left", exp_wr.size(), 0);
         exp_wr.delete();
         exp_rd.delete();
         exp_done.delete();
         @(posedge clk); #1;
         chk_reset_outputs("abort_rst");
         rst = 1'b0;
         repeat (8) @(posedge clk);
         #1;
         chk_ram("ram_after_abort");
      end else begin
         guard = 0;
         while (exp_done.size() != 0 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
         end
         chk("done_seen", exp_done.size(), 0);
         exp_wr.delete();
         exp_rd.delete();
         exp_done.delete();
         if (corrupt && n >= 2) mem_exp[8'(base + 1)] = ~d[1];
         chk_ram("ram_image");
         repeat (3) @(posedge clk);
         #1;
         chk("error_hold", bus.error, e.err);
         chk("count_hold", bus.count, n);
         chk("idle_busy", bus.busy, 0);
      end
      corrupt_req = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0;
      bus.base_addr = '0;
      bus.length = '0;
      bus.s_valid = 1'b0;
      bus.s_data = '0;
      for (int k = 0; k < 256; k++) known[k] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      run_load(8'h00, 4, 0, 1, 0, -1);
      run_load(8'hFE, 4, 0, 0, 0, -1);
      run_load(8'h80, 9'h100, 1, 0, 0, -1);
      run_load(8'h33, 0, 0, 0, 0, -1);
      run_load(8'h40, 9'h1FF, 0, 0, 0, -1);
      run_load(8'h10, 6, 0, 0, 1, -1);
      run_load(8'h20, 3, 1, 0, 0, -1);
      run_load(8'h50, 5, 0, 0, 0, 2);
      run_load(8'h50, 5, 0, 0, 0, -1);
      for (int t = 0; t < 6; t++)
         run_load($urandom_range(0, 255), $urandom_range(1, 20), t[0], 0, t == 3, -1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
